// File: rtl/mirfak_divider.sv
// Iterative 32-bit restoring divider for RV32M DIV/DIVU/REM/REMU.
// One quotient bit per cycle; the pipeline is held via div_stall_o until the result pulse.
module mirfak_divider (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        div_start_i,
    input  logic [1:0]  div_op_i,
    input  logic [31:0] div_dividend_i,
    input  logic [31:0] div_divisor_i,
    input  logic        div_kill_i,
    output logic [31:0] div_result_o,
    output logic        div_ready_o,
    output logic        div_stall_o,
    output logic [1:0]  div_state_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  op_q, op_d;
    logic        sign_a_q, sign_a_d;
    logic        sign_b_q, sign_b_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] result_q, result_d;

    // Operand decode for the IDLE-cycle launch
    logic        in_signed;
    logic        in_sign_a;
    logic        in_sign_b;
    logic [31:0] in_mag_a;
    logic [31:0] in_mag_b;
    logic        in_div_zero;
    logic        in_overflow;

    // One restoring step on the current {remainder, quotient} pair
    logic [32:0] r_shift;
    logic [32:0] trial;
    logic [31:0] step_rem;
    logic [31:0] step_quo;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;

    always_comb begin
        in_signed   = ~div_op_i[0];
        in_sign_a   = in_signed & div_dividend_i[31];
        in_sign_b   = in_signed & div_divisor_i[31];
        in_mag_a    = in_sign_a ? (32'd0 - div_dividend_i) : div_dividend_i;
        in_mag_b    = in_sign_b ? (32'd0 - div_divisor_i) : div_divisor_i;
        in_div_zero = (div_divisor_i == 32'd0);
        in_overflow = in_signed && (div_dividend_i == 32'h8000_0000)
                      && (div_divisor_i == 32'hFFFF_FFFF);
    end

    // The remainder is always below the divisor, so the trial result fits in 32 bits.
    always_comb begin
        r_shift  = {rem_q, quo_q[31]};
        trial    = r_shift - {1'b0, dvs_q};
        step_rem = trial[32] ? r_shift[31:0] : trial[31:0];
        step_quo = {quo_q[30:0], ~trial[32]};
        quo_fix  = (~op_q[0] & (sign_a_q ^ sign_b_q)) ? (32'd0 - step_quo) : step_quo;
        rem_fix  = (~op_q[0] & sign_a_q) ? (32'd0 - step_rem) : step_rem;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        sign_a_d = sign_a_q;
        sign_b_d = sign_b_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dvs_d    = dvs_q;
        result_d = result_q;

        case (state_q)
            IDLE: begin
                if (div_start_i) begin
                    op_d     = div_op_i;
                    sign_a_d = in_sign_a;
                    sign_b_d = in_sign_b;
                    rem_d    = 32'd0;
                    quo_d    = in_mag_a;
                    dvs_d    = in_mag_b;
                    cnt_d    = 5'd31;
                    if (in_div_zero) begin
                        result_d = div_op_i[1] ? div_dividend_i : 32'hFFFF_FFFF;
                        state_d  = DONE;
                    end else if (in_overflow) begin
                        result_d = div_op_i[1] ? 32'd0 : 32'h8000_0000;
                        state_d  = DONE;
                    end else begin
                        state_d  = BUSY;
                    end
                end
            end
            BUSY: begin
                rem_d = step_rem;
                quo_d = step_quo;
                if (cnt_q == 5'd0) begin
                    result_d = op_q[1] ? rem_fix : quo_fix;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q - 5'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A flush wins over everything: abandon the work and keep the old result.
        if (div_kill_i) begin
            state_d  = IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q  <= IDLE;
            cnt_q    <= 5'd0;
            op_q     <= 2'd0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            rem_q    <= 32'd0;
            quo_q    <= 32'd0;
            dvs_q    <= 32'd0;
            result_q <= 32'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            sign_a_q <= sign_a_d;
            sign_b_q <= sign_b_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dvs_q    <= dvs_d;
            result_q <= result_d;
        end
    end

    // Handshake: div_start_i is held by EX; div_stall_o holds the pipeline while the
    // op is accepted or iterating; div_ready_o marks the single cycle in which
    // div_result_o is valid and the pipeline advances. div_kill_i suppresses both.
    assign div_ready_o  = (state_q == DONE) & ~div_kill_i;
    assign div_stall_o  = ~div_kill_i & (((state_q == IDLE) & div_start_i) | (state_q == BUSY));
    assign div_result_o = result_q;
    assign div_state_o  = state_q;

endmodule
